encoder_serial: RTL and testbench



---
 rtl/encoder_serial_pkg.sv | 15 +
 rtl/encoder_serial_priority_lsb_encoder.sv | 28 ++
 rtl/encoder_serial.sv | 82 ++++++++
 tb/tb_encoder_serial.sv | 188 ++++++++++++++++++
 4 files changed

// File: rtl/encoder_serial_pkg.sv
// Shared definitions for the serial one-hot/multi-hot to binary encoder.
//   state_t     : FSM state encoding (IDLE = 0, EMIT = 1)
//   size_legal  : configuration check, SIZE must fit in a BITS-wide index
package encoder_serial_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    EMIT = 1'b1
  } state_t;

  function automatic bit size_legal(input int bits, input int size);
    return (size >= 1) && (size <= (1 << bits));
  endfunction

endpackage

// File: rtl/encoder_serial_priority_lsb_encoder.sv
// Combinational lowest-set-bit encoder.
//   vec    : input vector
//   idx    : index of the lowest set bit (0 when vec is zero)
//   onehot : the lowest set bit isolated (vec & -vec)
//   single : exactly one bit of vec is set
module priority_lsb_encoder #(
  parameter int BITS = 2,
  parameter int SIZE = 4
) (
  input  logic [SIZE-1:0] vec,
  output logic [BITS-1:0] idx,
  output logic [SIZE-1:0] onehot,
  output logic            single
);

  // Scan from the top down so the lowest set bit is the last to win.
  always_comb begin
    idx = '0;
    for (int i = SIZE - 1; i >= 0; i--) begin
      if (vec[i]) idx = BITS'(i);
    end
  end

  assign onehot = vec & (~vec + SIZE'(1));
  // Clearing the lowest bit leaves nothing only when a single bit was set.
  assign single = (vec != '0) && ((vec & (vec - SIZE'(1))) == '0);

endmodule

// File: rtl/encoder_serial.sv
// Serial multi-hot to binary encoder. Accepts a SIZE-bit request vector and
// emits the index of every set bit, lowest first, one per output handshake.
//   clk, rst_n           : clock, asynchronous active-low reset
//   in_valid/in_ready    : input handshake, in_vec sampled on accept only
//   in_vec               : request vector, bit i requests index i
//   out_valid/out_ready  : output handshake
//   out_idx              : index of the lowest pending bit
//   out_last             : out_idx is the final pending bit of the vector
//   busy                 : a vector is being emitted (~in_ready)
module encoder_serial
  import encoder_serial_pkg::*;
#(
  parameter int BITS = 2,
  parameter int SIZE = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [SIZE-1:0] in_vec,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [BITS-1:0] out_idx,
  output logic            out_last,
  output logic            busy
);

  if (!size_legal(BITS, SIZE)) begin : g_bad_cfg
    $error("encoder_serial: SIZE must be between 1 and 2**BITS");
  end

  state_t          state;
  logic [SIZE-1:0] pending;
  logic [BITS-1:0] enc_idx;
  logic [SIZE-1:0] enc_onehot;
  logic            enc_single;

  priority_lsb_encoder #(
    .BITS (BITS),
    .SIZE (SIZE)
  ) u_enc (
    .vec    (pending),
    .idx    (enc_idx),
    .onehot (enc_onehot),
    .single (enc_single)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      pending <= '0;
    end else begin
      case (state)
        IDLE: begin
          // A zero vector is accepted but has nothing to emit.
          if (in_valid && (in_vec != '0)) begin
            pending <= in_vec;
            state   <= EMIT;
          end
        end
        EMIT: begin
          if (out_ready) begin
            pending <= pending & ~enc_onehot;
            if (enc_single) state <= IDLE;
          end
        end
        default: begin
          state   <= IDLE;
          pending <= '0;
        end
      endcase
    end
  end

  // Outputs decode from registered state and pending only.
  assign busy      = (state == EMIT);
  assign in_ready  = ~busy;
  assign out_valid = busy;
  assign out_idx   = busy ? enc_idx : '0;
  assign out_last  = busy & enc_single;

endmodule

// File: tb/tb_encoder_serial.sv
module tb_encoder_serial;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;

  logic       in_valid4 = 1'b0;
  logic       in_ready4;
  logic [3:0] in_vec4 = '0;
  logic       out_valid4;
  logic       out_ready4 = 1'b0;
  logic [1:0] out_idx4;
  logic       out_last4;
  logic       busy4;

  logic       in_valid8 = 1'b0;
  logic       in_ready8;
  logic [7:0] in_vec8 = '0;
  logic       out_valid8;
  logic       out_ready8 = 1'b0;
  logic [2:0] out_idx8;
  logic       out_last8;
  logic       busy8;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  encoder_serial #(.BITS(2), .SIZE(4)) dut4 (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid4),
    .in_ready  (in_ready4),
    .in_vec    (in_vec4),
    .out_valid (out_valid4),
    .out_ready (out_ready4),
    .out_idx   (out_idx4),
    .out_last  (out_last4),
    .busy      (busy4)
  );

  encoder_serial #(.BITS(3), .SIZE(8)) dut8 (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid8),
    .in_ready  (in_ready8),
    .in_vec    (in_vec8),
    .out_valid (out_valid8),
    .out_ready (out_ready8),
    .out_idx   (out_idx8),
    .out_last  (out_last8),
    .busy      (busy8)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // out_valid, out_idx, out_last, in_ready, busy of the 4-bit instance
  task automatic check4(input string tag, input logic v, input logic [1:0] i,
                        input logic l);
    check({tag, ".out_valid"}, 32'(out_valid4), 32'(v));
    check({tag, ".out_idx"},   32'(out_idx4),   32'(i));
    check({tag, ".out_last"},  32'(out_last4),  32'(l));
    check({tag, ".in_ready"},  32'(in_ready4),  32'(!v));
    check({tag, ".busy"},      32'(busy4),      32'(v));
  endtask

  logic [2:0] exp8 [2];
  int         k;
  logic [2:0] prev_idx;
  logic       prev_stall;
  logic       stalled_once;

  initial begin
    exp8[0] = 3'd0;
    exp8[1] = 3'd7;

    // Reset asserted from time zero, checked before any clock edge.
    #2;
    check4("reset_initial", 1'b0, 2'd0, 1'b0);
    check("reset_initial.out_valid8", 32'(out_valid8), 32'(0));
    check("reset_initial.in_ready8", 32'(in_ready8), 32'(1));
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    check4("idle_after_reset", 1'b0, 2'd0, 1'b0);

    // 4'b1011 with out_ready held high: 0, 1, 3.
    in_valid4 = 1'b1; in_vec4 = 4'b1011; out_ready4 = 1'b1;
    tick();
    in_valid4 = 1'b0; in_vec4 = 4'b0000;
    check4("v1011_c0", 1'b1, 2'd0, 1'b0);
    tick();
    check4("v1011_c1", 1'b1, 2'd1, 1'b0);
    tick();
    check4("v1011_c2", 1'b1, 2'd3, 1'b1);
    tick();
    check4("v1011_done", 1'b0, 2'd0, 1'b0);

    // 4'b0110 with three stalled cycles, ready on the fourth.
    in_valid4 = 1'b1; in_vec4 = 4'b0110; out_ready4 = 1'b0;
    tick();
    in_valid4 = 1'b0; in_vec4 = 4'b1111;
    for (int c = 0; c < 4; c++) begin
      check4("bp_hold", 1'b1, 2'd1, 1'b0);
      out_ready4 = (c == 3);
      tick();
    end
    check4("bp_second", 1'b1, 2'd2, 1'b1);
    tick();
    check4("bp_done", 1'b0, 2'd0, 1'b0);

    // Zero vector is accepted and discarded.
    in_valid4 = 1'b1; in_vec4 = 4'b0000;
    tick();
    check4("zero_vec", 1'b0, 2'd0, 1'b0);
    in_vec4 = 4'b0100;
    tick();
    in_valid4 = 1'b0; in_vec4 = 4'b0000;
    check4("after_zero", 1'b1, 2'd2, 1'b1);
    tick();
    check4("after_zero_done", 1'b0, 2'd0, 1'b0);

    // Reset in the middle of emitting 4'b1111.
    in_valid4 = 1'b1; in_vec4 = 4'b1111;
    tick();
    in_valid4 = 1'b0; in_vec4 = 4'b0000;
    check4("v1111_c0", 1'b1, 2'd0, 1'b0);
    tick();
    check4("v1111_c1", 1'b1, 2'd1, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    check4("reset_mid_emit", 1'b0, 2'd0, 1'b0);
    tick();
    rst_n = 1'b1;
    tick();
    check4("after_reset_release", 1'b0, 2'd0, 1'b0);
    in_valid4 = 1'b1; in_vec4 = 4'b1000;
    tick();
    in_valid4 = 1'b0; in_vec4 = 4'b0000;
    check4("v1000", 1'b1, 2'd3, 1'b1);
    tick();
    check4("v1000_done", 1'b0, 2'd0, 1'b0);

    // BITS=3, SIZE=8: 8'h81 with random out_ready; first cycle forced stall.
    in_valid8 = 1'b1; in_vec8 = 8'h81;
    tick();
    in_valid8 = 1'b0; in_vec8 = 8'h00;
    k = 0;
    prev_stall = 1'b0;
    prev_idx = '0;
    stalled_once = 1'b0;
    for (int c = 0; c < 60 && k < 2; c++) begin
      check("w8.out_valid", 32'(out_valid8), 32'(1));
      check("w8.out_idx", 32'(out_idx8), 32'(exp8[k]));
      check("w8.out_last", 32'(out_last8), 32'(k == 1));
      if (prev_stall) check("w8.hold", 32'(out_idx8), 32'(prev_idx));
      out_ready8 = (c == 0) ? 1'b0 : ($urandom_range(0, 1) == 1);
      if (c == 0) stalled_once = 1'b1;
      prev_idx = out_idx8;
      prev_stall = !out_ready8;
      tick();
      if (out_ready8) k++;
    end
    out_ready8 = 1'b0;
    check("w8.all_emitted", 32'(k), 32'(2));
    check("w8.stall_seen", 32'(stalled_once), 32'(1));
    check("w8.done_valid", 32'(out_valid8), 32'(0));
    check("w8.done_ready", 32'(in_ready8), 32'(1));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
